iram_prog: RTL and testbench



---
 rtl/iram_pkg.sv | 23 ++
 rtl/iram_load_fsm.sv | 119 +++++++++++
 rtl/iram_prog.sv | 112 +++++++++++
 tb/tb_iram_prog.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types and defaults for the programmable instruction RAM.
package iram_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } iram_state_e;

  // Word written by the clear sweep; all-zero decodes as a NOP for the core.
  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam int IRAM_DATA_W = 16;
  localparam int IRAM_ADDR_W = 8;
  localparam int IRAM_DEPTH  = 128;

  // Bits needed to index DEPTH words (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iram_load_fsm.sv
// Loader control: clear sweep after reset, then valid/ready word stream at a base index.
module iram_load_fsm
  import iram_pkg::*;
#(
  parameter int DEPTH  = IRAM_DEPTH,
  parameter int ADDR_W = IRAM_ADDR_W,
  parameter int CW     = $clog2(DEPTH) + 1,
  parameter int IW     = idx_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic [ADDR_W-2:0] ld_base,
  input  logic            ld_valid,
  input  logic            ld_last,
  output logic            busy,
  output logic            ld_ready,
  output logic            ld_done,
  output logic            ld_err,
  output logic [CW-1:0]   ld_count,
  output logic            clr_we,
  output logic            ld_we,
  output logic [IW-1:0]   wr_idx
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   DEPTH_U = 32'(DEPTH);

  iram_state_e   state_q, state_d;
  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [31:0]   base_u;
  logic [CW-1:0] base_sat;

  // A base at or past the end starts the pointer at DEPTH so every word overflows.
  always_comb begin
    base_u   = 32'(ld_base);
    base_sat = (base_u >= DEPTH_U) ? DEPTH_C : CW'(base_u);
  end

  // Next-state, pointer, count and error update; wptr doubles as the clear pointer.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    clr_we  = 1'b0;
    ld_we   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (wptr_q == DEPTH_C - CW'(1)) begin
          state_d = S_IDLE;
          wptr_d  = '0;
        end else begin
          wptr_d = wptr_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          wptr_d  = base_sat;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          // Words past the end are accepted and dropped so the stream drains to LAST.
          if (wptr_q < DEPTH_C) begin
            ld_we  = 1'b1;
            wptr_d = wptr_q + CW'(1);
            cnt_d  = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (ld_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        wptr_d  = '0;
      end
    endcase
  end

  // Control registers; reset restarts the clear sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      wptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy     = (state_q != S_IDLE);
    ld_ready = (state_q == S_LOAD);
    ld_done  = (state_q == S_DONE);
    ld_err   = err_q;
    ld_count = cnt_q;
    wr_idx   = wptr_q[IW-1:0];
  end

endmodule

// File: rtl/iram_prog.sv
// Instruction RAM with runtime program load and a combinational or registered fetch port.
module iram_prog
  import iram_pkg::*;
#(
  parameter int DATA_W   = IRAM_DATA_W,
  parameter int ADDR_W   = IRAM_ADDR_W,
  parameter int DEPTH    = IRAM_DEPTH,
  parameter int READ_REG = 0,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              MISALIGN,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic [ADDR_W-2:0] LD_BASE,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic [CW-1:0]     LD_COUNT
);

  localparam int          IW      = idx_w(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic              ld_we;
  logic [IW-1:0]     wr_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-2:0] rd_idx;
  logic [DATA_W-1:0] rd_word;

  iram_load_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CW     (CW),
    .IW     (IW)
  ) u_load_fsm (
    .clk      (CLK),
    .rst      (RESET),
    .ld_start (LD_START),
    .ld_base  (LD_BASE),
    .ld_valid (LD_VALID),
    .ld_last  (LD_LAST),
    .busy     (BUSY),
    .ld_ready (LD_READY),
    .ld_done  (LD_DONE),
    .ld_err   (LD_ERR),
    .ld_count (LD_COUNT),
    .clr_we   (clr_we),
    .ld_we    (ld_we),
    .wr_idx   (wr_idx)
  );

  // Write mux: clear sweep stores NOPs, load stores the streamed word.
  always_comb begin
    mem_we    = clr_we | ld_we;
    mem_wdata = clr_we ? DATA_W'(NOP_WORD) : LD_DATA;
  end

  // Array write port; contents are not reset, the clear sweep initialises them.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wr_idx] <= mem_wdata;
    end
  end

  // Fetch decode: byte address to word index, low bit only flags misalignment.
  always_comb begin
    rd_idx   = ADDR[ADDR_W-1:1];
    MISALIGN = ADDR[0];
    if (32'(rd_idx) < DEPTH_U) begin
      rd_word = mem_q[rd_idx[IW-1:0]];
    end else begin
      rd_word = '0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] q_q, q_d;

      // Registered read samples the array before this edge's write lands (old data).
      always_comb begin
        q_d = rd_word;
      end

      // Output register with one cycle of fetch latency.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          q_q <= '0;
        end else begin
          q_q <= q_d;
        end
      end

      assign Q = q_q;
    end else begin : g_rd_comb
      assign Q = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_iram_prog.sv
// Directed bench for iram_prog: one combinational-read and one registered-read instance share stimulus.
module tb_iram_prog;

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  ADDR;
  logic        LD_START;
  logic [6:0]  LD_BASE;
  logic        LD_VALID;
  logic [15:0] LD_DATA;
  logic        LD_LAST;

  logic [15:0] q0, q1;
  logic        mis0, mis1, busy0, busy1, rdy0, rdy1, done0, done1, err0, err1;
  logic [7:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ldw [32];

  always #5 clk = ~clk;

  iram_prog #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .READ_REG(0), .CW(8)) u_dut0 (
    .CLK(clk), .RESET(RESET), .ADDR(ADDR), .Q(q0), .MISALIGN(mis0), .BUSY(busy0),
    .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_VALID(LD_VALID), .LD_READY(rdy0),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_DONE(done0), .LD_ERR(err0), .LD_COUNT(cnt0)
  );

  iram_prog #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .READ_REG(1), .CW(8)) u_dut1 (
    .CLK(clk), .RESET(RESET), .ADDR(ADDR), .Q(q1), .MISALIGN(mis1), .BUSY(busy1),
    .LD_START(LD_START), .LD_BASE(LD_BASE), .LD_VALID(LD_VALID), .LD_READY(rdy1),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_DONE(done1), .LD_ERR(err1), .LD_COUNT(cnt1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stat(input string tag, input logic b, input logic r, input logic d,
                          input logic e, input logic [7:0] c);
    chk_eq({tag, "_busy0"}, 32'(busy0), 32'(b));
    chk_eq({tag, "_busy1"}, 32'(busy1), 32'(b));
    chk_eq({tag, "_rdy0"},  32'(rdy0),  32'(r));
    chk_eq({tag, "_rdy1"},  32'(rdy1),  32'(r));
    chk_eq({tag, "_done0"}, 32'(done0), 32'(d));
    chk_eq({tag, "_done1"}, 32'(done1), 32'(d));
    chk_eq({tag, "_err0"},  32'(err0),  32'(e));
    chk_eq({tag, "_err1"},  32'(err1),  32'(e));
    chk_eq({tag, "_cnt0"},  32'(cnt0),  32'(c));
    chk_eq({tag, "_cnt1"},  32'(cnt1),  32'(c));
  endtask

  // Read one address: combinational Q now, registered Q after one edge.
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    ADDR = a;
    #1;
    chk_eq({tag, "_q0"}, 32'(q0), 32'(exp));
    tick();
    chk_eq({tag, "_q1"}, 32'(q1), 32'(exp));
  endtask

  // Count cycles with BUSY high, bounded.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 1000) begin
      tick();
      n++;
    end
    chk_eq({tag, "_busy_cycles"}, 32'(n), 32'd128);
  endtask

  // Stream n words of ldw[] from base; abort_at >= 0 stops after that many handshakes.
  task automatic do_load(input string tag, input int base, input int n, input bit gaps,
                         input int abort_at);
    int  k;
    bit  aborted;
    aborted  = 1'b0;
    LD_BASE  = 7'(base);
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    chk_eq({tag, "_err_clr"}, 32'(err0), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (!aborted) begin
        if (i == abort_at) begin
          aborted = 1'b1;
        end else begin
          if (gaps) begin
            LD_VALID = 1'b0;
            LD_DATA  = 16'hDEAD;
            LD_LAST  = 1'b1;
            tick();
          end
          LD_VALID = 1'b1;
          LD_DATA  = ldw[i];
          LD_LAST  = (i == n - 1);
          k = 0;
          while (!rdy0 && k < 50) begin
            tick();
            k++;
          end
          chk_eq({tag, "_rdy_wait"}, 32'(k < 50), 32'd1);
          tick();
        end
      end
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    if (!aborted) begin
      chk_eq({tag, "_done_pulse"}, 32'(done0), 32'd1);
      chk_eq({tag, "_done_rdy"},   32'(rdy0),  32'd0);
      chk_eq({tag, "_done_busy"},  32'(busy0), 32'd1);
      tick();
      chk_eq({tag, "_done_end"},   32'(done0), 32'd0);
      chk_eq({tag, "_idle_busy"},  32'(busy0), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET    = 1'b1;
    ADDR     = 8'h00;
    LD_START = 1'b0;
    LD_BASE  = 7'd0;
    LD_VALID = 1'b0;
    LD_DATA  = 16'h0000;
    LD_LAST  = 1'b0;
    for (int i = 0; i < 32; i++) ldw[i] = 16'h0000;

    // 1: reset state, clear sweep length, all words NOP
    tick();
    tick();
    chk_stat("rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk_eq("rst_q1", 32'(q1), 32'd0);
    RESET = 1'b0;
    wait_clear("t1");
    chk_stat("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int a = 0; a < 256; a += 2) rd_chk("t1_zero", 8'(a), 16'h0000);

    // 2: contiguous 19-word load at base 0
    for (int i = 0; i < 19; i++) ldw[i] = 16'h1000 + 16'(i) * 16'h0101;
    ldw[0] = 16'hF491;
    ldw[2] = 16'h54BF;
    do_load("t2", 0, 19, 1'b0, -1);
    chk_stat("t2_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd19);
    rd_chk("t2_w0", 8'h00, 16'hF491);
    rd_chk("t2_w2", 8'h04, 16'h54BF);
    rd_chk("t2_w19", 8'h26, 16'h0000);
    for (int i = 0; i < 19; i++) rd_chk("t2_all", 8'(2 * i), ldw[i]);

    // 3: same load after a fresh clear, LD_VALID toggling
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    wait_clear("t3");
    do_load("t3", 0, 19, 1'b1, -1);
    chk_stat("t3_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd19);
    for (int i = 0; i < 19; i++) rd_chk("t3_all", 8'(2 * i), ldw[i]);
    rd_chk("t3_w19", 8'h26, 16'h0000);

    // 4: overflow at the top of the array
    ldw[0] = 16'hAAAA;
    ldw[1] = 16'hBBBB;
    ldw[2] = 16'hCCCC;
    ldw[3] = 16'hDDDD;
    do_load("t4", 126, 4, 1'b0, -1);
    chk_stat("t4_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    rd_chk("t4_w126", 8'hFC, 16'hAAAA);
    rd_chk("t4_w127", 8'hFE, 16'hBBBB);
    rd_chk("t4_w0", 8'h00, 16'hF491);

    // 5: reset after 3 of 10 words
    for (int i = 0; i < 10; i++) ldw[i] = 16'h7700 + 16'(i);
    do_load("t5", 10, 10, 1'b0, 3);
    chk_eq("t5_cnt_mid", 32'(cnt0), 32'd3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_stat("t5_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_clear("t5");
    for (int a = 0; a < 256; a += 2) rd_chk("t5_zero", 8'(a), 16'h0000);

    // 6: misaligned fetch, registered latency, read-during-write
    ldw[0] = 16'h1111;
    ldw[1] = 16'h2222;
    ldw[2] = 16'h3333;
    ldw[3] = 16'h4444;
    do_load("t6", 0, 4, 1'b0, -1);
    ADDR = 8'h00;
    tick();
    chk_eq("t6_q1_a0", 32'(q1), 32'h1111);
    ADDR = 8'h05;
    #1;
    chk_eq("t6_mis0", 32'(mis0), 32'd1);
    chk_eq("t6_mis1", 32'(mis1), 32'd1);
    chk_eq("t6_q0_a5", 32'(q0), 32'h3333);
    chk_eq("t6_q1_lat", 32'(q1), 32'h1111);
    tick();
    chk_eq("t6_q1_a5", 32'(q1), 32'h3333);
    ADDR = 8'h04;
    #1;
    chk_eq("t6_mis_al", 32'(mis0), 32'd0);
    tick();
    LD_BASE  = 7'd2;
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    LD_VALID = 1'b1;
    LD_DATA  = 16'h5555;
    LD_LAST  = 1'b1;
    tick();
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    chk_eq("t6_rdw_old", 32'(q1), 32'h3333);
    chk_eq("t6_rdw_q0", 32'(q0), 32'h5555);
    tick();
    chk_eq("t6_rdw_new", 32'(q1), 32'h5555);
    chk_stat("t6_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
